// File: rtl/pipe_pkg.sv
// Shared types for the five-stage core pipeline registers: handshake state
// encoding, occupancy width and the packed payloads carried between stages.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'b00,
    PS_ONE   = 2'b01,
    PS_FULL  = 2'b10
  } pipe_state_e;

  // Width of the entries-held count (0..2).
  localparam int unsigned OCC_W = 2;

  // IF/ID payload.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
  } if_id_t;

  // ID/EX payload.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  funct3;
  } id_ex_t;

  // EX/MEM payload.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  funct3;
  } ex_mem_t;

  // MEM/WB payload.
  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_we;
  } mem_wb_t;

  // Number of entries held in a given handshake state.
  function automatic logic [OCC_W-1:0] occ_of_state(input pipe_state_e s);
    logic [OCC_W-1:0] occ;
    occ = '0;
    case (s)
      PS_ONE:  occ = 2'd1;
      PS_FULL: occ = 2'd2;
      default: occ = '0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts cycles with inc_i high, sticks at all-ones,
// cleared only by synchronous reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: advance on inc_i unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic elastic pipeline stage register: two entries (main + skid) under a
// valid/ready handshake with a registered in_ready_o, plus pipeline flush.
// Optional stall/bubble counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter bit          CLEAR_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [OCC_W-1:0]  occupancy_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

  if (DATA_W < 1) begin : g_bad_data_w
    $error("pipe_stage_skid: DATA_W must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipe_stage_skid: CNT_W must be at least 1");
  end

  pipe_state_e       state_q;
  pipe_state_e       state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_d;
  logic              in_ready_q;
  logic              in_ready_d;

  logic              in_fire;
  logic              out_fire;
  logic              out_valid;

  assign out_valid = (state_q != PS_EMPTY);
  assign in_fire   = in_valid_i & in_ready_q;
  assign out_fire  = out_valid & out_ready_i;

  // Handshake state machine and payload steering; flush overrides the normal
  // moves, and in_ready is precomputed from the next state so it stays a flop.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush_i) begin
      // Any concurrent in_fire is accepted and dropped; out_fire is delivered.
      state_d = PS_EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data_i;
            state_d = PS_ONE;
          end
        end
        PS_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            skid_d  = in_data_i;
            state_d = PS_FULL;
          end else if (out_fire) begin
            state_d = PS_EMPTY;
          end
        end
        PS_FULL: begin
          // in_ready is low here, so only the drain move is possible.
          if (out_fire) begin
            main_d  = skid_q;
            state_d = PS_ONE;
          end
        end
        default: begin
          state_d = PS_EMPTY;
        end
      endcase
    end

    in_ready_d = (state_d != PS_FULL);
  end

  // State, payload and ready registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= PS_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid;
  assign out_data_o  = main_q;
  assign occupancy_o = occ_of_state(state_q);

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;
  logic bubble_inc;

  // Classification uses the registered out_valid, so a flush cycle counts
  // according to what was presented before the flush.
  assign stall_inc  = out_valid & ~out_ready_i;
  assign bubble_inc = ~out_valid;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (bubble_inc),
    .cnt_o (bubble_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: two instances share stimulus, one with
// payload clearing on flush and one without. Counter checks are built when
// PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_skid;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          in_ready_c,  in_ready_n;
  logic          out_valid_c, out_valid_n;
  logic [DW-1:0] out_data_c,  out_data_n;
  logic [1:0]    occ_c,       occ_n;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_c,  stall_n;
  logic [CW-1:0] bubble_c, bubble_n;
`endif

  int unsigned n_vec = 0;
  int unsigned n_miscmp = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W         (DW),
    .CLEAR_ON_FLUSH (1'b1),
    .CNT_W          (CW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready_c),
    .in_data_i    (in_data),
    .out_valid_o  (out_valid_c),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data_c),
    .occupancy_o  (occ_c)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt_o  (stall_c),
    .bubble_cnt_o (bubble_c)
`endif
  );

  pipe_stage_skid #(
    .DATA_W         (DW),
    .CLEAR_ON_FLUSH (1'b0),
    .CNT_W          (CW)
  ) dut_nc (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready_n),
    .in_data_i    (in_data),
    .out_valid_o  (out_valid_n),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data_n),
    .occupancy_o  (occ_n)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt_o  (stall_n),
    .bubble_cnt_o (bubble_n)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stage(input string tag, input logic vld, input logic rdy,
                             input logic [1:0] occ, input logic [31:0] data);
    check_eq({tag, ".valid"}, {31'd0, out_valid_c}, {31'd0, vld});
    check_eq({tag, ".ready"}, {31'd0, in_ready_c},  {31'd0, rdy});
    check_eq({tag, ".occ"},   {30'd0, occ_c},       {30'd0, occ});
    check_eq({tag, ".data"},  out_data_c,           data);
  endtask

  // Toggle-pattern table: offered data index, out_ready, expected results.
  logic [31:0] tg_off  [8] = '{0, 1, 2, 3, 3, 4, 4, 5};
  logic        tg_ordy [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  logic [31:0] tg_out  [8] = '{0, 1, 1, 2, 2, 3, 3, 4};
  logic [1:0]  tg_occ  [8] = '{1, 1, 2, 1, 2, 1, 2, 1};
  logic        tg_rdy  [8] = '{1, 1, 0, 1, 0, 1, 0, 1};

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check_stage("reset", 1'b0, 1'b1, 2'd0, 32'h0);
`ifdef PIPE_STAGE_PERF_EN
    check_eq("reset.stall",  {28'd0, stall_c},  32'd0);
    check_eq("reset.bubble", {28'd0, bubble_c}, 32'd0);
`endif
    rst = 1'b0;

    // Back-to-back stream with downstream always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int unsigned i = 1; i <= 3; i++) begin
      in_data = i;
      tick();
      check_stage($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, i);
    end
    in_valid = 1'b0;
    tick();
    check_stage("stream_drain", 1'b0, 1'b1, 2'd0, 32'h3);

    // Backpressure: fill both entries, 0xC held off, then drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    check_stage("bp_a", 1'b1, 1'b1, 2'd1, 32'hA);
    in_data = 32'hB;
    tick();
    check_stage("bp_full", 1'b1, 1'b0, 2'd2, 32'hA);
    in_data = 32'hC;
    tick();
    check_stage("bp_hold", 1'b1, 1'b0, 2'd2, 32'hA);
    out_ready = 1'b1;
    tick();
    check_stage("bp_b", 1'b1, 1'b1, 2'd1, 32'hB);
    tick();
    check_stage("bp_c", 1'b1, 1'b1, 2'd1, 32'hC);
    in_valid = 1'b0;
    tick();
    check_stage("bp_empty", 1'b0, 1'b1, 2'd0, 32'hC);

    // Flush while FULL with 0xC offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    check_stage("fl_full", 1'b1, 1'b0, 2'd2, 32'hA);
    in_data = 32'hC;
    flush   = 1'b1;
    tick();
    check_stage("fl_clear", 1'b0, 1'b1, 2'd0, 32'h0);
    check_eq("fl_nc.valid", {31'd0, out_valid_n}, 32'd0);
    check_eq("fl_nc.occ",   {30'd0, occ_n},       32'd0);
    check_eq("fl_nc.data",  out_data_n,           32'hA);
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check_stage("fl_after", 1'b0, 1'b1, 2'd0, 32'h0);
    check_eq("fl_nc.after", out_data_n, 32'hA);

    // Flush in EMPTY with an input accepted: it must be dropped.
    in_valid = 1'b1;
    in_data  = 32'hD;
    flush    = 1'b1;
    tick();
    check_stage("fl_drop", 1'b0, 1'b1, 2'd0, 32'h0);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    check_stage("fl_drop2", 1'b0, 1'b1, 2'd0, 32'h0);

    // out_ready toggling every cycle with a continuous producer.
    in_valid = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      in_data   = 32'h20 + tg_off[i];
      out_ready = tg_ordy[i];
      tick();
      check_stage($sformatf("tog%0d", i), 1'b1, tg_rdy[i], tg_occ[i], 32'h20 + tg_out[i]);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_stage("tog_drain", 1'b0, 1'b1, 2'd0, 32'h24);

    // Reset while FULL drops everything.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    tick();
    in_data = 32'h66;
    tick();
    check_stage("rst_full", 1'b1, 1'b0, 2'd2, 32'h55);
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    check_stage("rst_mid", 1'b0, 1'b1, 2'd0, 32'h0);
    check_eq("rst_mid.nc", out_data_n, 32'h0);
    rst = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
    // One bubble cycle while loading, then a long stall that saturates.
    in_valid = 1'b1;
    in_data  = 32'h77;
    tick();
    in_valid = 1'b0;
    check_eq("perf.bubble1", {28'd0, bubble_c}, 32'd1);
    check_eq("perf.stall0",  {28'd0, stall_c},  32'd0);
    for (int unsigned i = 0; i < 14; i++) tick();
    check_eq("perf.stall14", {28'd0, stall_c}, 32'd14);
    tick();
    check_eq("perf.stall15", {28'd0, stall_c}, 32'd15);
    for (int unsigned i = 0; i < 5; i++) tick();
    check_eq("perf.stall_sat", {28'd0, stall_c},  32'd15);
    check_eq("perf.bubble",    {28'd0, bubble_c}, 32'd1);
    // Flush cycle with an entry held counts as a stall; counters survive flush.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("perf.fl_bubble", {28'd0, bubble_c}, 32'd1);
    tick();
    check_eq("perf.post_bubble", {28'd0, bubble_c}, 32'd2);
    check_eq("perf.post_stall",  {28'd0, stall_c},  32'd15);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
